// File: rtl/mode3_exp_ctrl.sv
// Control for the two-stage mode3_exp datapath: valid/ready handshake, stage enables,
// occupancy tracking with backpressure, and row counting from start to done.
module mode3_exp_ctrl #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] row_len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             stage_run2,
    output logic             stage_run,
    output logic             dp_reset,
    output logic             busy,
    output logic             done
);

    // state   | meaning
    // S_IDLE  | waiting for start; row_len sampled with start
    // S_RUN   | accepting input beats until in_rem reaches 0
    // S_DRAIN | all beats accepted; emptying stages A and B
    // S_DONE  | one-cycle done pulse, then back to idle
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             v_a;
    logic             v_b;
    logic [CNT_W-1:0] in_rem;
    logic [CNT_W-1:0] out_rem;
    logic             adv_a;
    logic             adv_b;
    logic             out_fire;

    always_comb begin
        // Enables are gated with reset so the datapath never moves while it is being cleared.
        adv_b     = reset & v_a & (~v_b | out_ready);
        in_ready  = reset & (state == S_RUN) & (in_rem != '0) & (~v_a | adv_b);
        adv_a     = in_valid & in_ready;
        out_fire  = v_b & out_ready;
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (row_len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (adv_a && in_rem == CNT_W'(1)) state_nxt = S_DRAIN;
            S_DRAIN: if (out_fire && out_rem == CNT_W'(1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            v_a     <= 1'b0;
            v_b     <= 1'b0;
            in_rem  <= '0;
            out_rem <= '0;
        end else begin
            state <= state_nxt;
            v_a   <= adv_a | (v_a & ~adv_b);
            v_b   <= adv_b | (v_b & ~out_ready);
            if (state == S_IDLE && start) begin
                in_rem  <= row_len;
                out_rem <= row_len;
            end else begin
                if (adv_a) in_rem <= in_rem - CNT_W'(1);
                if (out_fire && out_rem != '0) out_rem <= out_rem - CNT_W'(1);
            end
        end
    end

    assign out_valid  = v_b;
    assign out_last   = v_b & (out_rem == CNT_W'(1));
    assign stage_run2 = adv_a;
    assign stage_run  = adv_b;
    assign dp_reset   = ~reset;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

endmodule

// File: tb/tb_mode3_exp_ctrl.sv
// Bench for mode3_exp_ctrl: slot-based pipeline model checked every cycle, a tag datapath
// driven by the stage enables to verify ordering, plus hand-computed directed expectations.
module tb_mode3_exp_ctrl;

    localparam int CNT_W = 10;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] row_len;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             stage_run2;
    logic             stage_run;
    logic             dp_reset;
    logic             busy;
    logic             done;

    mode3_exp_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .row_len(row_len),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .stage_run2(stage_run2),
        .stage_run(stage_run), .dp_reset(dp_reset), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: two slots (A, B) holding beat tags or -1, plus row bookkeeping.
    int  phase = P_IDLE;
    int  slot_a = -1, slot_b = -1;
    int  len = 0, acc = 0, emit = 0, g_acc = 0;
    bit  started = 0;
    bit  e_in_ready, e_acc, e_run, e_ov, e_last;
    bit  s_sr2, s_sr;
    int  dp_a = -1, dp_b = -1;

    always @(negedge clk) begin
        if (started) begin
            e_run      = reset && slot_a >= 0 && (slot_b < 0 || out_ready);
            e_in_ready = reset && phase == P_RUN && acc < len && (slot_a < 0 || e_run);
            e_acc      = e_in_ready && in_valid;
            e_ov       = slot_b >= 0;
            e_last     = e_ov && (emit == len - 1);
            chk("in_ready", in_ready, e_in_ready);
            chk("stage_run2", stage_run2, e_acc);
            chk("stage_run", stage_run, e_run);
            chk("out_valid", out_valid, e_ov);
            chk("out_last", out_last, e_last);
            chk("busy", busy, phase != P_IDLE);
            chk("done", done, phase == P_DONE);
            chk("dp_reset", dp_reset, !reset);
            if (e_ov) chk("data_order", dp_b, slot_b);
            s_sr2 = stage_run2;
            s_sr  = stage_run;
        end
    end

    always @(posedge clk) begin
        int na, nb;
        if (!reset) begin
            dp_a = -1;
            dp_b = -1;
        end else begin
            if (s_sr) dp_b = dp_a;
            if (s_sr2) dp_a = g_acc;
        end
        if (!reset) begin
            phase = P_IDLE; slot_a = -1; slot_b = -1; len = 0; acc = 0; emit = 0;
        end else begin
            na = slot_a;
            nb = slot_b;
            if (e_ov && out_ready) begin
                emit++;
                nb = -1;
            end
            if (e_run) begin
                nb = slot_a;
                na = -1;
            end
            if (e_acc) begin
                na = g_acc;
                g_acc++;
                acc++;
            end
            slot_a = na;
            slot_b = nb;
            case (phase)
                P_IDLE:  if (start) begin
                             len = int'(row_len); acc = 0; emit = 0;
                             phase = (row_len == 0) ? P_DONE : P_RUN;
                         end
                P_RUN:   if (acc == len) phase = P_DRAIN;
                P_DRAIN: if (emit == len) phase = P_DONE;
                default: phase = P_IDLE;
            endcase
        end
        e_run = 0; e_acc = 0; e_ov = 0;
        s_sr2 = 0; s_sr = 0;
        started = 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start = 0; in_valid = 0; out_ready = 1;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int cnt;
        int hold;
        reset = 0; start = 0; row_len = '0; in_valid = 0; out_ready = 0;
        step();
        step();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dp_reset", dp_reset, 1);
        reset = 1;
        step();

        // Streaming, row_len=4.
        start = 1; row_len = 4; in_valid = 1; out_ready = 1;
        step();
        start = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("stream_in_ready", in_ready, c <= 4);
            chk("stream_out_valid", out_valid, c >= 3 && c <= 6);
            chk("stream_out_last", out_last, c == 6);
            chk("stream_done", done, c == 7);
            step();
        end
        @(negedge clk);
        chk("stream_busy_off", busy, 0);
        idle(2);

        // Backpressure, row_len=3, out_ready low in cycles 3-6.
        start = 1; row_len = 3; in_valid = 1; out_ready = 1;
        step();
        start = 0;
        hold = 0;
        for (int c = 1; c <= 10; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            @(negedge clk);
            if (c >= 3 && c <= 6) chk("bp_in_ready_low", in_ready, 0);
            if (c == 3) hold = dp_b;
            if (c >= 4 && c <= 6) chk("bp_hold", dp_b, hold);
            if (c == 7) begin
                chk("bp_concurrent_sr2", stage_run2, 1);
                chk("bp_concurrent_sr", stage_run, 1);
                chk("bp_concurrent_in_ready", in_ready, 1);
            end
            if (c == 9) chk("bp_last", out_last, 1);
            chk("bp_done", done, c == 10);
            step();
        end
        idle(2);

        // Bubbles, row_len=5, in_valid high on odd cycles.
        start = 1; row_len = 5; in_valid = 0; out_ready = 1;
        step();
        start = 0;
        cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            in_valid = (c % 2) == 1;
            @(negedge clk);
            chk("bub_sr2", stage_run2, (c % 2) == 1 && c <= 9);
            chk("bub_last", out_last, c == 11);
            chk("bub_done", done, c == 12);
            if (out_valid) cnt++;
            step();
        end
        chk("bub_out_count", cnt, 5);
        idle(2);

        // Zero-length row.
        start = 1; row_len = 0;
        step();
        start = 0;
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 1);
        chk("zero_sr2", stage_run2, 0);
        step();
        @(negedge clk);
        chk("zero_done_off", done, 0);
        chk("zero_busy_off", busy, 0);
        idle(1);

        // Start pulsed during RUN is ignored.
        start = 1; row_len = 3; in_valid = 0; out_ready = 1;
        step();
        cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            start = (c == 1);
            row_len = (c == 1) ? 10'd7 : 10'd3;
            in_valid = (c >= 2);
            @(negedge clk);
            if (stage_run2) cnt++;
            chk("ign_done", done, c == 7);
            step();
        end
        chk("ign_accepts", cnt, 3);
        idle(2);

        // Mid-row reset after 3 accepts, then a fresh row.
        start = 1; row_len = 8; in_valid = 1; out_ready = 1;
        step();
        start = 0;
        for (int c = 1; c <= 8; c++) begin
            reset = !(c == 4 || c == 5);
            @(negedge clk);
            if (c <= 3) chk("mrr_accept", stage_run2, 1);
            if (c == 4) chk("mrr_sr2_gated", stage_run2, 0);
            if (c == 5) begin
                chk("mrr_in_ready", in_ready, 0);
                chk("mrr_out_valid", out_valid, 0);
                chk("mrr_out_last", out_last, 0);
                chk("mrr_sr", stage_run, 0);
                chk("mrr_busy", busy, 0);
                chk("mrr_dp_reset", dp_reset, 1);
            end
            if (c >= 5) chk("mrr_no_done", done, 0);
            step();
        end
        in_valid = 0;
        start = 1; row_len = 2; in_valid = 1; out_ready = 1;
        step();
        start = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("fresh_last", out_last, c == 4);
            chk("fresh_done", done, c == 5);
            step();
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
